// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the five-stage MIPS core: opcode constants, the
//   canonical NOP word, the default reset PC, an instruction field view and
//   register-usage helpers for the opcodes the core implements.
//   This file has no ports; import it with "import mips_pkg::*;".
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Field view of an instruction word; the low half is immediate or
    // rd/shamt/funct depending on the format.
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] low;
    } ins_fields_t;

    // Does the instruction read rs as a source operand?
    function automatic logic uses_rs(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_BEQ, OP_LW, OP_SW, OP_ORI, OP_ADDIU: uses_rs = 1'b1;
            default:                                          uses_rs = 1'b0;
        endcase
    endfunction

    // Does the instruction read rt as a source operand? For lw/ori/addiu/lui
    // rt is a destination, so it cannot create a load-use dependency.
    function automatic logic uses_rt(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_BEQ, OP_SW: uses_rt = 1'b1;
            default:                 uses_rt = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
//   Combinational load-use hazard detector. Flags when the instruction in ID
//   reads a register that the load currently in ID/EX is about to write.
// Ports:
//   id_ins      in  32  instruction held in IF/ID
//   id_valid    in  1   id_ins is a real instruction
//   ex_memread  in  1   instruction in ID/EX is a load
//   ex_rt       in  5   destination register of the load in ID/EX
//   hazard      out 1   ID must stall one cycle
module hazard_detect
    import mips_pkg::*;
(
    input  logic [31:0] id_ins,
    input  logic        id_valid,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    output logic        hazard
);

    ins_fields_t f;
    logic        rs_match;
    logic        rt_match;
    logic        unused_low;

    assign f          = id_ins;
    assign unused_low = ^f.low;

    assign rs_match = uses_rs(f.op) && (f.rs == ex_rt);
    assign rt_match = uses_rt(f.op) && (f.rt == ex_rt);

    // $0 is hard-wired to zero, so a load "into" $0 never creates a dependency.
    assign hazard = id_valid && ex_memread && (ex_rt != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage
//   IF/ID pipeline register with load-use stall and taken-branch/jump flush,
//   plus saturating stall/flush event counters for debug.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   if_pc        in  32     PC of the instruction being fetched
//   if_ins       in  32     fetched instruction word
//   br_taken3    in  1      branch taken in EX/MEM
//   jmp3         in  1      jump resolving in EX/MEM
//   ex_memread   in  1      instruction in ID/EX is a load
//   ex_rt        in  5      destination register of the ID/EX instruction
//   id_pc        out 32     registered PC for decode
//   id_ins       out 32     registered instruction for decode
//   id_valid     out 1      id_ins is a real, non-squashed instruction
//   pc_hold      out 1      IFU must not update pc this cycle
//   ex_bubble    out 1      ID/EX must load a NOP this cycle
//   ex_flush     out 1      ID/EX must be squashed (wrong path)
//   stall_cnt    out CNT_W  saturating count of stall cycles
//   flush_cnt    out CNT_W  saturating count of flush events
//
// Control contract: pc_hold, ex_bubble and ex_flush are level signals valid
// for the current cycle only and are computed from registered IF/ID state and
// same-cycle EX/MEM inputs, never from if_ins. The IFU advances its pc on
// every posedge where pc_hold is low; flush always forces pc_hold low so a
// redirect can never be blocked by a stall.
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_ins,
    input  logic             br_taken3,
    input  logic             jmp3,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_ins,
    output logic             id_valid,
    output logic             pc_hold,
    output logic             ex_bubble,
    output logic             ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0]      id_pc_q,     id_pc_d;
    logic [31:0]      id_ins_q,    id_ins_d;
    logic             id_valid_q,  id_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hazard;
    logic flush;
    logic stall;

    hazard_detect u_hazard_detect (
        .id_ins     (id_ins_q),
        .id_valid   (id_valid_q),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .hazard     (hazard)
    );

    // Flush has priority: a wrong-path instruction must not stall the pipe.
    assign flush = br_taken3 | jmp3;
    assign stall = hazard & ~flush;

    always_comb begin
        id_pc_d    = id_pc_q;
        id_ins_d   = id_ins_q;
        id_valid_d = id_valid_q;
        if (flush) begin
            // Squash the wrong-path instruction; keep if_pc for debug visibility.
            id_pc_d    = if_pc;
            id_ins_d   = NOP;
            id_valid_d = 1'b0;
        end else if (!hazard) begin
            id_pc_d    = if_pc;
            id_ins_d   = if_ins;
            id_valid_d = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc_q     <= RESET_PC;
            id_ins_q    <= NOP;
            id_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            id_pc_q     <= id_pc_d;
            id_ins_q    <= id_ins_d;
            id_valid_q  <= id_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign id_pc     = id_pc_q;
    assign id_ins    = id_ins_q;
    assign id_valid  = id_valid_q;
    assign pc_hold   = stall;
    assign ex_bubble = stall;
    assign ex_flush  = flush;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
